ristretto_csr_perf_counters: RTL and testbench
==============================================

# ristretto_csr_perf_counters

Machine performance-counter CSR bank for the ristretto core: mcycle, minstret, NumHpm programmable mhpmcounterN/mhpmeventN pairs and mcountinhibit. It is parametrised in counter count and width. It sits beside the trap/status CSR regfile on the same CSR opcode interface. The decode stage ORs both banks' read data and uses `csr_hit_o` to flag illegal CSR addresses.

## Interface
- `DataWidth`, 32: CSR data width; only 32 is supported.
- `NumHpm`, 4: number of hpm counters, 0..29, mapped to indices 3..3+NumHpm-1.
- `CounterWidth`, 64: implemented counter width, 33..64.
- `clk_i`  in  1  core clock.
- `rstn_i`  in  1  reset. One clock; reset is asynchronous and active-low.
- `csr_addr_i`  in  12  CSR address.
- `csr_wdata_i`  in  DataWidth  CSR write operand.
- `csr_op_i`  in  3  operation select:
  - bit `CSR_OP_R_BIT` = read.
  - [1:0] = 11 write, 01 set, 10 clear, 00 none.
- `csr_en_i`  in  1  CSR instruction valid.
- `instr_retire_i`  in  1  one instruction retires this cycle.
- `hpm_event_i`  in  NumHpm (min 1)  event strobes, one per cycle each.
- `csr_rdata_o`  out  DataWidth  read data.
- `csr_hit_o`  out  1  address decodes to this bank.

## Operation
- **Counters**
  - C0 = mcycle (0xB00 lo / 0xB80 hi).
  - C2 = minstret (0xB02 / 0xB82).
  - Ci = mhpmcounter i (0xB00+i / 0xB80+i) for i in 3..NumHpm+2.
- **mcountinhibit (0x320)**
  - bit0 = CY, bit2 = IR, bit i = HPMi.
  - bit1 and unimplemented bits are hardwired 0.
- **mhpmevent i (0x320+i)**
  - 5-bit select k; upper bits read 0.
  - k in 1..NumHpm: counter i counts `hpm_event_i[k-1]`.
  - k = 0 or k > NumHpm: counter i never counts.
- **Increment conditions** (each counter adds +1 per qualifying cycle)
  - mcycle: every cycle while CY=0.
  - minstret: `instr_retire_i` while IR=0.
  - hpm i: selected event high while HPMi=0.
- **Wrap**
  - Counters wrap modulo 2^CounterWidth.
  - High-half bits at or above CounterWidth-32 read 0 and ignore writes.
- **Writes** (write, set or clear when `csr_en_i` and op[1:0] != 00)
  - Set = old | wdata; clear = old & ~wdata.
  - A lo-half write replaces bits [31:0] only; a hi-half write replaces the upper bits only.
- **Read**
  - Combinational: when `csr_en_i` and the R bit is set, `csr_rdata_o` shows the current register value.
  - Otherwise, or on a miss, `csr_rdata_o` = 0.
- **Decode**
  - `csr_hit_o` is combinational and independent of op.
  - It is 1 only for implemented addresses: 0xB01, 0xB81 and 0x321 are misses, as are hpm indices >= NumHpm+3.
- User shadows (0xC00 range) and mcounteren are not decoded.

## Timing
- **Reset**: all counters, mcountinhibit and mhpmevent clear to 0. `csr_rdata_o` = 0 and `csr_hit_o` = 0 while inputs are idle.
- Write latency is 1 cycle: the new value is readable the cycle after the write.
- **Write vs. increment, same counter, same cycle**: the write wins and the increment is dropped. A lo-half write leaves the hi half unchanged, including any carry that increment would have produced.
- **Write to the other half**: the unwritten half holds its value, so no increment occurs that cycle.
- **Inhibit write**: the cycle of the write counts using the old inhibit value; the new value applies from the next edge.
- **mhpmevent write**: same rule as an inhibit write; the new select applies from the next edge.
- **Carry**: lo = 0xFFFFFFFF with increment gives lo = 0 and hi+1 in the same edge. There is no split carry cycle.
- **Asynchronous reset mid-count**: all state clears immediately. Counting resumes on the first edge after deassertion.
- Reading 0xB00 during a write to 0xB00 returns the pre-write value.

## Structure
- Constants in `ristretto_csr_pkg`:
  - MCYCLE, MINSTRET, MHPMCOUNTER3, MCYCLEH, MINSTRETH, MHPMCOUNTER3H, MCOUNTINHIBIT, MHPMEVENT3.
  - HPM_EVENT_SEL_WIDTH = 5.
  - Bit positions COUNTINHIBIT_CY_BIT = 0, COUNTINHIBIT_IR_BIT = 2.
  - Reuse CSR_OP_R_BIT.
- Sub-module `ristretto_perf_counter`, parameter Width:
  - Inputs: inc_i, inhibit_i, wr_lo_i, wr_hi_i, wdata_i.
  - Output: count_o.
  - Contains the write-priority and carry logic.
- The bank generates NumHpm+2 instances, plus decode and op arithmetic.

## Test plan
- **Reset and idle**: release reset, 10 cycles, read 0xB00 -> 10 (if the read is sampled before edge 10, 9). Read 0xB80 -> 0, `csr_hit_o` = 1.
- **Carry**:
  - Write 0xB00 = 0xFFFFFFFE, then 0xB80 = 0x1.
  - Two cycles later read lo = 0x00000000, hi = 0x2.
  - With CounterWidth = 40, hi 0xFF wraps to 0.
- **Inhibit**:
  - Write 0x320 = 0x5, pulse `instr_retire_i` 5 times: mcycle and minstret are frozen.
  - Clear bit2, 3 retires -> minstret +3, mcycle still frozen.
- **Event select**:
  - mhpmevent3 = 2, mhpmevent4 = 0, pulse `hpm_event_i[1]` 4 times -> mhpmcounter3 = 4, mhpmcounter4 = 0.
  - mhpmevent3 = 31 -> no counting.
- **Write priority**: in the same cycle write 0xB00 = 0x100 while counting -> next-cycle read is 0x100, not 0x101.
- **Set/clear and decode**:
  - Set 0x320 with 0xFFFFFFFF -> reads 0x7D (NumHpm = 4).
  - Clear with 0x1 -> reads 0x7C.
  - Addresses 0xB01, 0x321 and 0xB07 -> `csr_hit_o` = 0 and `csr_rdata_o` = 0.

Source files
------------

// File: rtl/ristretto_csr_pkg.sv
// ristretto_csr_pkg
//   Shared CSR constants for the ristretto core: performance-counter CSR
//   addresses, mcountinhibit bit positions, CSR opcode encoding and the
//   small helpers the counter bank uses for decode and op arithmetic.
package ristretto_csr_pkg;

    localparam logic [11:0] MCYCLE        = 12'hB00;
    localparam logic [11:0] MINSTRET      = 12'hB02;
    localparam logic [11:0] MHPMCOUNTER3  = 12'hB03;
    localparam logic [11:0] MCYCLEH       = 12'hB80;
    localparam logic [11:0] MINSTRETH     = 12'hB82;
    localparam logic [11:0] MHPMCOUNTER3H = 12'hB83;
    localparam logic [11:0] MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] MHPMEVENT3    = 12'h323;

    localparam int HPM_EVENT_SEL_WIDTH = 5;
    localparam int COUNTINHIBIT_CY_BIT = 0;
    localparam int COUNTINHIBIT_IR_BIT = 2;

    // csr_op_i[2] requests read data; csr_op_i[1:0] selects the modify op.
    localparam int CSR_OP_R_BIT = 2;

    typedef enum logic [1:0] {
        CSR_OP_NONE  = 2'b00,
        CSR_OP_SET   = 2'b01,
        CSR_OP_CLEAR = 2'b10,
        CSR_OP_WRITE = 2'b11
    } csr_op_e;

    function automatic logic [31:0] csr_apply_op(input csr_op_e op,
                                                 input logic [31:0] old,
                                                 input logic [31:0] wdata);
        case (op)
            CSR_OP_WRITE: return wdata;
            CSR_OP_SET:   return old | wdata;
            CSR_OP_CLEAR: return old & ~wdata;
            default:      return old;
        endcase
    endfunction

    // Writable mcountinhibit bits: CY, IR and one bit per implemented hpm.
    function automatic logic [31:0] inhibit_mask(input int num_hpm);
        logic [31:0] m;
        m = '0;
        m[COUNTINHIBIT_CY_BIT] = 1'b1;
        m[COUNTINHIBIT_IR_BIT] = 1'b1;
        for (int i = 3; i < 32; i++) begin
            if (i < 3 + num_hpm) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Counter slot j in the bank -> CSR index (mcycle=0, minstret=2, hpm=j+1).
    function automatic int unsigned counter_csr_idx(input int j);
        return (j == 0) ? 0 : j + 1;
    endfunction

endpackage

// File: rtl/ristretto_perf_counter.sv
// ristretto_perf_counter
//   One wrapping performance counter with independent lo/hi half writes.
//   Ports:
//     clk_i, rstn_i  clock, async active-low reset
//     inc_i          count event this cycle
//     inhibit_i      suppress counting
//     wr_lo_i        replace bits [31:0] with wdata_i
//     wr_hi_i        replace bits [Width-1:32] with low bits of wdata_i
//     wdata_i        already-resolved write value (set/clear applied)
//     count_o        current counter value
module ristretto_perf_counter #(
    parameter int Width = 64
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             inc_i,
    input  logic             inhibit_i,
    input  logic             wr_lo_i,
    input  logic             wr_hi_i,
    input  logic [31:0]      wdata_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_q, count_d;

    // A write to either half freezes the other half for that cycle, so the
    // increment (and any carry it would produce) is dropped entirely.
    always_comb begin
        count_d = count_q;
        if (wr_lo_i) begin
            count_d[31:0] = wdata_i;
        end else if (wr_hi_i) begin
            count_d[Width-1:32] = wdata_i[Width-33:0];
        end else if (inc_i && !inhibit_i) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) count_q <= '0;
        else         count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/ristretto_csr_perf_counters.sv
// ristretto_csr_perf_counters
//   Machine performance-counter CSR bank: mcycle, minstret, NumHpm
//   mhpmcounter/mhpmevent pairs and mcountinhibit.
//   Ports:
//     clk_i, rstn_i      clock, async active-low reset
//     csr_addr_i         CSR address
//     csr_wdata_i        write operand
//     csr_op_i           [2]=read, [1:0]=11 write / 01 set / 10 clear
//     csr_en_i           CSR instruction valid
//     instr_retire_i     one instruction retires this cycle
//     hpm_event_i        per-event strobes selectable by mhpmevent
//     csr_rdata_o        read data, 0 when not reading or on a miss
//     csr_hit_o          address is implemented in this bank
module ristretto_csr_perf_counters
    import ristretto_csr_pkg::*;
#(
    parameter int DataWidth    = 32,
    parameter int NumHpm       = 4,
    parameter int CounterWidth = 64
) (
    input  logic                                clk_i,
    input  logic                                rstn_i,
    input  logic [11:0]                         csr_addr_i,
    input  logic [DataWidth-1:0]                csr_wdata_i,
    input  logic [2:0]                          csr_op_i,
    input  logic                                csr_en_i,
    input  logic                                instr_retire_i,
    input  logic [((NumHpm > 0) ? NumHpm : 1)-1:0] hpm_event_i,
    output logic [DataWidth-1:0]                csr_rdata_o,
    output logic                                csr_hit_o
);

    localparam int          NumCnt  = NumHpm + 2;
    localparam int          EvW     = (NumHpm > 0) ? NumHpm : 1;
    localparam logic [31:0] InhMask = inhibit_mask(NumHpm);

    logic [31:0]                               inhibit_q, inhibit_d;
    logic [EvW-1:0][HPM_EVENT_SEL_WIDTH-1:0]   evsel_q, evsel_d;
    logic [NumCnt-1:0][CounterWidth-1:0]       count;
    logic [NumCnt-1:0]                         cnt_inc, cnt_inh, cnt_wr_lo, cnt_wr_hi, sel_cnt;
    logic [EvW-1:0]                            sel_evt;
    logic                                      sel_inh, hit, wr_en;
    logic                                      in_lo_page, in_hi_page, in_evt_page;
    int unsigned                               idx;
    logic [31:0]                               cur_val, new_val, ev_ext;

    // Decode: counters live at 0xB00/0xB80 + idx, inhibit/events at 0x320 + idx.
    assign idx         = 32'(csr_addr_i[4:0]);
    assign in_lo_page  = (csr_addr_i[11:5] == MCYCLE[11:5]);
    assign in_hi_page  = (csr_addr_i[11:5] == MCYCLEH[11:5]);
    assign in_evt_page = (csr_addr_i[11:5] == MCOUNTINHIBIT[11:5]);

    always_comb begin
        hit     = 1'b0;
        cur_val = '0;
        sel_inh = 1'b0;
        sel_evt = '0;
        sel_cnt = '0;
        if (in_evt_page) begin
            if (idx == 0) begin
                hit     = 1'b1;
                sel_inh = 1'b1;
                cur_val = inhibit_q;
            end
            for (int k = 0; k < NumHpm; k++) begin
                if (idx == k + 3) begin
                    hit        = 1'b1;
                    sel_evt[k] = 1'b1;
                    cur_val    = 32'(evsel_q[k]);
                end
            end
        end
        if (in_lo_page || in_hi_page) begin
            for (int j = 0; j < NumCnt; j++) begin
                if (idx == counter_csr_idx(j)) begin
                    hit        = 1'b1;
                    sel_cnt[j] = 1'b1;
                    cur_val    = in_hi_page ? 32'(count[j][CounterWidth-1:32])
                                            : count[j][31:0];
                end
            end
        end
    end

    // Modify ops act on the pre-write value, which is also what a read sees.
    assign wr_en     = csr_en_i && (csr_op_i[1:0] != CSR_OP_NONE);
    assign new_val   = csr_apply_op(csr_op_e'(csr_op_i[1:0]), cur_val, csr_wdata_i);
    assign cnt_wr_lo = {NumCnt{wr_en & in_lo_page}} & sel_cnt;
    assign cnt_wr_hi = {NumCnt{wr_en & in_hi_page}} & sel_cnt;

    assign csr_hit_o   = hit;
    assign csr_rdata_o = (csr_en_i && csr_op_i[CSR_OP_R_BIT] && hit) ? cur_val : '0;

    always_comb begin
        inhibit_d = inhibit_q;
        evsel_d   = evsel_q;
        if (wr_en && sel_inh) inhibit_d = new_val & InhMask;
        for (int k = 0; k < NumHpm; k++) begin
            if (wr_en && sel_evt[k]) evsel_d[k] = new_val[HPM_EVENT_SEL_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            inhibit_q <= '0;
            evsel_q   <= '0;
        end else begin
            inhibit_q <= inhibit_d;
            evsel_q   <= evsel_d;
        end
    end

    // Bit 0 and bits above NumHpm stay 0, so select 0 or an out-of-range
    // select simply never counts.
    always_comb begin
        ev_ext = '0;
        for (int k = 0; k < NumHpm; k++) ev_ext[k+1] = hpm_event_i[k];
    end

    // Increment and inhibit use the registered inhibit/select, so a write
    // to either takes effect from the following edge.
    always_comb begin
        cnt_inc    = '0;
        cnt_inh    = '0;
        cnt_inc[0] = 1'b1;
        cnt_inh[0] = inhibit_q[COUNTINHIBIT_CY_BIT];
        cnt_inc[1] = instr_retire_i;
        cnt_inh[1] = inhibit_q[COUNTINHIBIT_IR_BIT];
        for (int k = 0; k < NumHpm; k++) begin
            cnt_inc[k+2] = ev_ext[evsel_q[k]];
            cnt_inh[k+2] = inhibit_q[k+3];
        end
    end

    for (genvar j = 0; j < NumCnt; j++) begin : g_cnt
        ristretto_perf_counter #(
            .Width(CounterWidth)
        ) u_cnt (
            .clk_i    (clk_i),
            .rstn_i   (rstn_i),
            .inc_i    (cnt_inc[j]),
            .inhibit_i(cnt_inh[j]),
            .wr_lo_i  (cnt_wr_lo[j]),
            .wr_hi_i  (cnt_wr_hi[j]),
            .wdata_i  (new_val),
            .count_o  (count[j])
        );
    end

endmodule

// File: tb/tb_ristretto_csr_perf_counters.sv
// Directed bench for ristretto_csr_perf_counters (NumHpm=4, CounterWidth=40).
module tb_ristretto_csr_perf_counters;
    import ristretto_csr_pkg::*;

    localparam int NumHpm = 4;
    localparam int CW     = 40;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [2:0]  csr_op;
    logic        csr_en;
    logic        retire;
    logic [NumHpm-1:0] hpm_ev;
    logic [31:0] rdata;
    logic        hit;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    ristretto_csr_perf_counters #(
        .DataWidth(32), .NumHpm(NumHpm), .CounterWidth(CW)
    ) u_dut (
        .clk_i(clk), .rstn_i(rstn), .csr_addr_i(csr_addr), .csr_wdata_i(csr_wdata),
        .csr_op_i(csr_op), .csr_en_i(csr_en), .instr_retire_i(retire),
        .hpm_event_i(hpm_ev), .csr_rdata_o(rdata), .csr_hit_o(hit)
    );

    task automatic idle();
        csr_en = 1'b0; csr_op = 3'b000; csr_addr = 12'h000; csr_wdata = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // One CSR cycle: drive, push expectation, sample at negedge, advance an edge.
    task automatic xfer(input logic [11:0] a, input logic en, input logic [2:0] op,
                        input logic [31:0] wd, input logic [31:0] exp, input logic exp_hit,
                        input string tag);
        logic [31:0] e;
        string t;
        csr_en = en; csr_op = op; csr_addr = a; csr_wdata = wd;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk(t, rdata, e);
        checks++;
        assert (hit === exp_hit) else begin
            errors++;
            $error("FAIL %s_hit: got=%b expected=%b", t, hit, exp_hit);
        end
        tick();
        idle();
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp, input logic exp_hit, input string tag);
        xfer(a, 1'b1, 3'b100, 32'h0, exp, exp_hit, tag);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] wd, input logic [1:0] op);
        csr_en = 1'b1; csr_op = {1'b0, op}; csr_addr = a; csr_wdata = wd;
        tick();
        idle();
    endtask

    initial begin
        idle();
        retire = 1'b0;
        hpm_ev = '0;
        #12;
        // reset state
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_hit", 32'(hit), 32'h0);
        rd(MCYCLE, 32'h0, 1'b1, "reset_mcycle");
        rstn = 1'b1;
        repeat (10) tick();
        rd(MCYCLE,  32'd10, 1'b1, "idle_mcycle");
        rd(MCYCLEH, 32'h0,  1'b1, "idle_mcycleh");

        // carry lo->hi in one edge; hi write freezes lo for that cycle
        wr(MCYCLE,  32'hFFFF_FFFE, CSR_OP_WRITE);
        wr(MCYCLEH, 32'h1,         CSR_OP_WRITE);
        rd(MCYCLE,  32'hFFFF_FFFE, 1'b1, "hold_lo_on_hi_wr");
        rd(MCYCLEH, 32'h1,         1'b1, "hi_written");
        rd(MCYCLE,  32'h0,         1'b1, "carry_lo");
        rd(MCYCLEH, 32'h2,         1'b1, "carry_hi");

        // 40-bit wrap, hi bits above 8 ignore writes
        wr(MCYCLEH, 32'hFFFF_FFFF, CSR_OP_WRITE);
        wr(MCYCLE,  32'hFFFF_FFFF, CSR_OP_WRITE);
        rd(MCYCLEH, 32'h0000_00FF, 1'b1, "hi_masked");
        rd(MCYCLEH, 32'h0,         1'b1, "wrap_hi");
        rd(MCYCLE,  32'h1,         1'b1, "wrap_lo");

        // inhibit CY and IR
        wr(MCOUNTINHIBIT, 32'h5, CSR_OP_WRITE);
        wr(MCYCLE,  32'h0, CSR_OP_WRITE);
        wr(MCYCLEH, 32'h0, CSR_OP_WRITE);
        rd(MCOUNTINHIBIT, 32'h5, 1'b1, "inhibit_rd");
        repeat (5) begin retire = 1'b1; tick(); retire = 1'b0; tick(); end
        rd(MCYCLE,   32'h0, 1'b1, "inh_mcycle");
        rd(MINSTRET, 32'h0, 1'b1, "inh_minstret");
        // retire during the clearing write still sees the old inhibit
        retire = 1'b1;
        wr(MCOUNTINHIBIT, 32'h4, CSR_OP_CLEAR);
        retire = 1'b0;
        repeat (3) begin retire = 1'b1; tick(); retire = 1'b0; tick(); end
        rd(MINSTRET,      32'h3, 1'b1, "ir_enabled");
        rd(MINSTRETH,     32'h0, 1'b1, "minstreth");
        rd(MCYCLE,        32'h0, 1'b1, "cy_still_inh");
        rd(MCOUNTINHIBIT, 32'h1, 1'b1, "inhibit_after_clr");

        // event select; strobe during the select write is not counted
        hpm_ev = 4'b0010;
        wr(MHPMEVENT3, 32'h2, CSR_OP_WRITE);
        hpm_ev = '0;
        wr(MHPMEVENT3 + 12'd1, 32'h0, CSR_OP_WRITE);
        repeat (4) begin hpm_ev = 4'b0011; tick(); hpm_ev = 4'b0001; tick(); hpm_ev = '0; end
        rd(MHPMCOUNTER3,          32'h4, 1'b1, "hpm3_cnt");
        rd(MHPMCOUNTER3 + 12'd1,  32'h0, 1'b1, "hpm4_sel0");
        rd(MHPMCOUNTER3H,         32'h0, 1'b1, "hpm3_hi");
        rd(MHPMEVENT3,            32'h2, 1'b1, "evsel_rd");
        wr(MHPMEVENT3, 32'd31, CSR_OP_WRITE);
        wr(MHPMEVENT3 + 12'd1, 32'hFFFF_FFFF, CSR_OP_WRITE);
        repeat (3) begin hpm_ev = 4'b1111; tick(); hpm_ev = '0; tick(); end
        rd(MHPMCOUNTER3,         32'h4,  1'b1, "hpm3_sel31");
        rd(MHPMCOUNTER3 + 12'd1, 32'h0,  1'b1, "hpm4_sel31");
        rd(MHPMEVENT3 + 12'd1,   32'h1F, 1'b1, "evsel_masked");
        wr(MHPMEVENT3 + 12'd3, 32'h4, CSR_OP_WRITE);
        repeat (2) begin hpm_ev = 4'b1000; tick(); hpm_ev = '0; tick(); end
        rd(MHPMCOUNTER3 + 12'd3, 32'h2, 1'b1, "hpm6_ev3");

        // write beats increment; read during write shows old value
        wr(MCOUNTINHIBIT, 32'h1, CSR_OP_CLEAR);
        wr(MCYCLE, 32'h50, CSR_OP_WRITE);
        xfer(MCYCLE, 1'b1, 3'b111, 32'h100, 32'h50, 1'b1, "rd_during_wr");
        rd(MCYCLE, 32'h100, 1'b1, "wr_priority");
        rd(MCYCLE, 32'h101, 1'b1, "count_after_wr");

        // lo write drops the carry the increment would have made
        wr(MCYCLEH, 32'h5,         CSR_OP_WRITE);
        wr(MCYCLE,  32'hFFFF_FFFF, CSR_OP_WRITE);
        wr(MCYCLE,  32'h7,         CSR_OP_WRITE);
        rd(MCYCLE,  32'h7, 1'b1, "lo_wr_lo");
        rd(MCYCLEH, 32'h5, 1'b1, "lo_wr_no_carry");

        // set/clear on mcountinhibit and decode
        wr(MCOUNTINHIBIT, 32'hFFFF_FFFF, CSR_OP_SET);
        rd(MCOUNTINHIBIT, 32'h7D, 1'b1, "inh_set");
        wr(MCOUNTINHIBIT, 32'h1, CSR_OP_CLEAR);
        rd(MCOUNTINHIBIT, 32'h7C, 1'b1, "inh_clr");
        rd(12'hB01, 32'h0, 1'b0, "miss_b01");
        rd(12'hB81, 32'h0, 1'b0, "miss_b81");
        rd(12'h321, 32'h0, 1'b0, "miss_321");
        rd(12'hB07, 32'h0, 1'b0, "miss_b07");
        rd(12'h327, 32'h0, 1'b0, "miss_327");
        rd(12'hC00, 32'h0, 1'b0, "miss_c00");
        rd(12'hB06, 32'h2, 1'b1, "hit_b06");
        rd(12'h326, 32'h4, 1'b1, "hit_326");
        xfer(MINSTRET, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1, "hit_no_op");

        // async reset mid-cycle
        #3;
        csr_en = 1'b1; csr_op = 3'b100; csr_addr = MCOUNTINHIBIT;
        rstn = 1'b0;
        #1;
        chk("async_rst_inh", rdata, 32'h0);
        idle();
        tick();
        rstn = 1'b1;
        repeat (3) tick();
        rd(MCYCLE,   32'h3, 1'b1, "post_rst_mcycle");
        rd(MINSTRET, 32'h0, 1'b1, "post_rst_minstret");
        rd(MHPMEVENT3 + 12'd3, 32'h0, 1'b1, "post_rst_evsel");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
